// File: rtl/execute_unit_mc.sv
// execute_unit_mc: execute stage with operand forwarding, a single-cycle ALU
// and an iterative shift-add multiplier / restoring divider. A one-entry
// result register (EX/MEM side) is loaded with a valid strobe.
//
// Handshake: an operation is accepted on a rising edge when inValid & inReady.
// inReady is high only in IDLE with no flush; stall = ~inReady. inValid while
// inReady is low is dropped, so upstream must hold the operation until accepted.
module execute_unit_mc #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic              flush,
    input  logic [WIDTH-1:0]  immediate,
    input  logic [WIDTH-1:0]  registerAData,
    input  logic [WIDTH-1:0]  registerBData,
    input  logic [WIDTH-1:0]  forwardWriteBackData,
    input  logic [FUNC_W-1:0] SIG_Function,
    input  logic              SIG_ALUSrc,
    input  logic [1:0]        SIG_ForwardA,
    input  logic [1:0]        SIG_ForwardB,
    output logic              outValid,
    output logic [WIDTH-1:0]  ALU_Result,
    output logic [WIDTH-1:0]  dataInMemory,
    output logic              zeroFlag,
    output logic              carryOutFlag,
    output logic              overflowFlag,
    output logic              negativeFlag,
    output logic              stall,
    output logic              dbg_state
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [FUNC_W-1:0] F_ADD   = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_SUB   = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_AND   = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_OR    = FUNC_W'(3);
    localparam logic [FUNC_W-1:0] F_XOR   = FUNC_W'(4);
    localparam logic [FUNC_W-1:0] F_SLL   = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_SRL   = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_SRA   = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] F_SLT   = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_SLTU  = FUNC_W'(9);
    localparam logic [FUNC_W-1:0] F_MUL   = FUNC_W'(16);
    localparam logic [FUNC_W-1:0] F_MULHU = FUNC_W'(17);
    localparam logic [FUNC_W-1:0] F_DIVU  = FUNC_W'(18);
    localparam logic [FUNC_W-1:0] F_REMU  = FUNC_W'(19);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // {remainder|product-hi, quotient|multiplier}
    logic [WIDTH-1:0]     opd_q, opd_d;     // multiplicand or divisor
    logic                 mc_mul_q, mc_mul_d;
    logic                 mc_hi_q, mc_hi_d; // result is the upper half of acc
    logic [WIDTH-1:0]     dim_hold_q, dim_hold_d;
    logic [WIDTH-1:0]     res_q, res_d, dim_q, dim_d;
    logic                 zf_q, zf_d, cf_q, cf_d, of_q, of_d, nf_q, nf_d;
    logic                 valid_q, valid_d;

    logic [WIDTH-1:0]     fwd_a, fwd_b, op_b;
    logic                 accept, is_mc;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_carry, sc_ovf, sc_def;
    logic [WIDTH:0]       sc_sum;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem, mc_res;
    logic [2*WIDTH-1:0]   step_next;

    assign inReady      = (state_q == S_IDLE) && !flush;
    assign stall        = ~inReady;
    assign accept       = inValid && inReady;
    assign is_mc        = (SIG_Function == F_MUL) || (SIG_Function == F_MULHU) ||
                          (SIG_Function == F_DIVU) || (SIG_Function == F_REMU);
    assign outValid     = valid_q;
    assign ALU_Result   = res_q;
    assign dataInMemory = dim_q;
    assign zeroFlag     = zf_q;
    assign carryOutFlag = cf_q;
    assign overflowFlag = of_q;
    assign negativeFlag = nf_q;
    assign dbg_state    = state_q;

    // Forwarding muxes; select 1 reads the stable EX/MEM result register.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        case (SIG_ForwardA)
            2'd0:    fwd_a = registerAData;
            2'd1:    fwd_a = res_q;
            2'd2:    fwd_a = forwardWriteBackData;
            default: fwd_a = '0;
        endcase
        case (SIG_ForwardB)
            2'd0:    fwd_b = registerBData;
            2'd1:    fwd_b = res_q;
            2'd2:    fwd_b = forwardWriteBackData;
            default: fwd_b = '0;
        endcase
        op_b = SIG_ALUSrc ? immediate : fwd_b;
    end

    // Single-cycle ALU on the live operands.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_def   = 1'b1;
        sc_sum   = {1'b0, fwd_a} + {1'b0, op_b};
        case (SIG_Function)
            F_ADD: begin
                sc_res   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
                sc_ovf   = (fwd_a[WIDTH-1] == op_b[WIDTH-1]) && (sc_res[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            F_SUB: begin
                sc_res   = fwd_a - op_b;
                sc_carry = (fwd_a >= op_b);
                sc_ovf   = (fwd_a[WIDTH-1] != op_b[WIDTH-1]) && (sc_res[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            F_AND:  sc_res = fwd_a & op_b;
            F_OR:   sc_res = fwd_a | op_b;
            F_XOR:  sc_res = fwd_a ^ op_b;
            F_SLL:  sc_res = fwd_a << op_b[SH_W-1:0];
            F_SRL:  sc_res = fwd_a >> op_b[SH_W-1:0];
            F_SRA:  sc_res = $unsigned($signed(fwd_a) >>> op_b[SH_W-1:0]);
            F_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            F_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (fwd_a < op_b)};
            default: sc_def = 1'b0;
        endcase
    end

    // One multiply (shift-add) or divide (restoring) iteration on acc_q.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, opd_q});
        div_rem   = div_ge ? WIDTH'(div_trial - {1'b0, opd_q}) : div_trial[WIDTH-1:0];
        if (mc_mul_q) step_next = {mul_sum, acc_q[WIDTH-1:1]};
        else          step_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
        mc_res = mc_hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    // FSM next state, operand capture and result-register load.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opd_d      = opd_q;
        mc_mul_d   = mc_mul_q;
        mc_hi_d    = mc_hi_q;
        dim_hold_d = dim_hold_q;
        res_d      = res_q;
        dim_d      = dim_q;
        zf_d       = zf_q;
        cf_d       = cf_q;
        of_d       = of_q;
        nf_d       = nf_q;
        valid_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mc) begin
                    state_d    = S_BUSY;
                    cnt_d      = CNT_W'(WIDTH-1);
                    mc_mul_d   = (SIG_Function == F_MUL) || (SIG_Function == F_MULHU);
                    mc_hi_d    = (SIG_Function == F_MULHU) || (SIG_Function == F_REMU);
                    opd_d      = mc_mul_d ? fwd_a : op_b;
                    acc_d      = {{WIDTH{1'b0}}, (mc_mul_d ? op_b : fwd_a)};
                    dim_hold_d = fwd_b;
                end else if (accept) begin
                    res_d   = sc_res;
                    zf_d    = sc_def && (sc_res == '0);
                    nf_d    = sc_res[WIDTH-1];
                    cf_d    = sc_carry;
                    of_d    = sc_ovf;
                    dim_d   = fwd_b;
                    valid_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        res_d   = mc_res;
                        zf_d    = (mc_res == '0);
                        nf_d    = mc_res[WIDTH-1];
                        cf_d    = 1'b0;
                        of_d    = 1'b0;
                        dim_d   = dim_hold_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opd_q      <= '0;
            mc_mul_q   <= 1'b0;
            mc_hi_q    <= 1'b0;
            dim_hold_q <= '0;
            res_q      <= '0;
            dim_q      <= '0;
            zf_q       <= 1'b0;
            cf_q       <= 1'b0;
            of_q       <= 1'b0;
            nf_q       <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opd_q      <= opd_d;
            mc_mul_q   <= mc_mul_d;
            mc_hi_q    <= mc_hi_d;
            dim_hold_q <= dim_hold_d;
            res_q      <= res_d;
            dim_q      <= dim_d;
            zf_q       <= zf_d;
            cf_q       <= cf_d;
            of_q       <= of_d;
            nf_q       <= nf_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_execute_unit_mc.sv
// Directed bench for execute_unit_mc: reset, ALU ops, multi-cycle ops,
// forwarding, flush and reset aborts.
module tb_execute_unit_mc;
    localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_MUL = 5'd16, F_MULHU = 5'd17,
                           F_DIVU = 5'd18, F_REMU = 5'd19;

    logic        clk = 1'b0;
    logic        reset, inValid, flush, SIG_ALUSrc;
    logic [31:0] immediate, registerAData, registerBData, forwardWriteBackData;
    logic [4:0]  SIG_Function;
    logic [1:0]  SIG_ForwardA, SIG_ForwardB;
    logic        inReady, outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag, stall, dbg_state;
    logic [31:0] ALU_Result, dataInMemory;

    int checks = 0;
    int failures = 0;

    execute_unit_mc #(.WIDTH(32), .FUNC_W(5)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .flush(flush),
        .immediate(immediate), .registerAData(registerAData), .registerBData(registerBData),
        .forwardWriteBackData(forwardWriteBackData), .SIG_Function(SIG_Function),
        .SIG_ALUSrc(SIG_ALUSrc), .SIG_ForwardA(SIG_ForwardA), .SIG_ForwardB(SIG_ForwardB),
        .outValid(outValid), .ALU_Result(ALU_Result), .dataInMemory(dataInMemory),
        .zeroFlag(zeroFlag), .carryOutFlag(carryOutFlag), .overflowFlag(overflowFlag),
        .negativeFlag(negativeFlag), .stall(stall), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] fa, input logic [1:0] fb, input logic src,
                            input logic [31:0] imm, input logic [31:0] wb);
        SIG_Function = f; registerAData = a; registerBData = b;
        SIG_ForwardA = fa; SIG_ForwardB = fb; SIG_ALUSrc = src;
        immediate = imm; forwardWriteBackData = wb; inValid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        drive_op(F_ADD, 32'd1, 32'd2, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step(); step();
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", outValid); end
        checks++; if (ALU_Result !== 32'd0) begin failures++; $display("FAIL rst_result got=%h exp=0", ALU_Result); end
        checks++; if (dataInMemory !== 32'd0) begin failures++; $display("FAIL rst_dim got=%h exp=0", dataInMemory); end
        checks++; if ({zeroFlag, carryOutFlag, overflowFlag, negativeFlag} !== 4'b0000) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {zeroFlag, carryOutFlag, overflowFlag, negativeFlag}); end
        checks++; if ({inReady, stall, dbg_state} !== 3'b100) begin
            failures++; $display("FAIL rst_ready got=%b exp=100", {inReady, stall, dbg_state}); end
        reset = 1'b0; inValid = 1'b0;
        step();
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL rst_post_valid got=%b exp=0", outValid); end
    endtask

    task automatic test_add_sub();
        drive_op(F_ADD, 32'h7FFFFFFF, 32'h1, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'h80000000) begin failures++; $display("FAIL add_res got=%h exp=80000000", ALU_Result); end
        checks++; if ({outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag} !== 5'b10011) begin
            failures++; $display("FAIL add_flags got=%b exp=10011", {outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag}); end
        drive_op(F_SUB, 32'd5, 32'd5, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'h0) begin failures++; $display("FAIL sub_res got=%h exp=0", ALU_Result); end
        checks++; if ({outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag} !== 5'b11100) begin
            failures++; $display("FAIL sub_flags got=%b exp=11100", {outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag}); end
        inValid = 1'b0;
        step();
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL sub_valid_drop got=%b exp=0", outValid); end
    endtask

    task automatic test_logic();
        logic [4:0]  fn [10];
        logic [31:0] ea [10];
        logic [31:0] eb [10];
        logic [31:0] er [10];
        logic        ez [10];
        fn = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd8};
        ea = '{32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'h1, 32'h80000000, 32'h80000000,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h1};
        eb = '{32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h24, 32'h4, 32'h4,
               32'h1, 32'h1, 32'h5, 32'hFFFFFFFF};
        er = '{32'h0000F000, 32'h0000FFF0, 32'h00000FF0, 32'h10, 32'h08000000, 32'hF8000000,
               32'h1, 32'h0, 32'h0, 32'h0};
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive_op(fn[i], ea[i], eb[i], 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
            step();
            checks++; if (ALU_Result !== er[i]) begin failures++; $display("FAIL logic_res[%0d] got=%h exp=%h", i, ALU_Result, er[i]); end
            checks++; if ({outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag} !== {1'b1, ez[i], 2'b00, er[i][31]}) begin
                failures++; $display("FAIL logic_flags[%0d] got=%b exp=%b", i,
                    {outValid, zeroFlag, carryOutFlag, overflowFlag, negativeFlag}, {1'b1, ez[i], 2'b00, er[i][31]}); end
        end
        inValid = 1'b0;
        step();
    endtask

    task automatic test_multicycle();
        logic [4:0]  fn [6];
        logic [31:0] ea [6];
        logic [31:0] eb [6];
        logic [31:0] er [6];
        int          cyc;
        logic        stall_bad;
        fn = '{F_MUL, F_MULHU, F_DIVU, F_REMU, F_DIVU, F_REMU};
        ea = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'h1234, 32'h1234};
        eb = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
        er = '{32'hFFFFFFFE, 32'h1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234};
        for (int i = 0; i < 6; i++) begin
            drive_op(fn[i], ea[i], eb[i], 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
            step();
            checks++; if ({stall, inReady, outValid, dbg_state} !== 4'b1001) begin
                failures++; $display("FAIL mc_busy[%0d] got=%b exp=1001", i, {stall, inReady, outValid, dbg_state}); end
            // Present a different op during stall; it must be dropped.
            drive_op(F_ADD, 32'd1, 32'd1, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
            cyc = 0;
            stall_bad = 1'b0;
            while (outValid !== 1'b1 && cyc < 40) begin
                step();
                cyc++;
                if (outValid !== 1'b1 && stall !== 1'b1) stall_bad = 1'b1;
            end
            inValid = 1'b0;
            checks++; if (cyc !== 32) begin failures++; $display("FAIL mc_latency[%0d] got=%0d exp=32", i, cyc); end
            checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL mc_stall[%0d] got=low exp=high", i); end
            checks++; if (ALU_Result !== er[i]) begin failures++; $display("FAIL mc_res[%0d] got=%h exp=%h", i, ALU_Result, er[i]); end
            checks++; if ({inReady, zeroFlag, carryOutFlag, overflowFlag, negativeFlag} !== {1'b1, (er[i] == 32'd0), 2'b00, er[i][31]}) begin
                failures++; $display("FAIL mc_flags[%0d] got=%b exp=%b", i,
                    {inReady, zeroFlag, carryOutFlag, overflowFlag, negativeFlag}, {1'b1, (er[i] == 32'd0), 2'b00, er[i][31]}); end
            checks++; if (dataInMemory !== eb[i]) begin failures++; $display("FAIL mc_dim[%0d] got=%h exp=%h", i, dataInMemory, eb[i]); end
            step();
            checks++; if (outValid !== 1'b0 || ALU_Result !== er[i]) begin
                failures++; $display("FAIL mc_hold[%0d] got=%b/%h exp=0/%h", i, outValid, ALU_Result, er[i]); end
        end
    endtask

    task automatic test_forward();
        drive_op(F_ADD, 32'd1, 32'd2, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'd3) begin failures++; $display("FAIL fwd_base got=%h exp=3", ALU_Result); end
        drive_op(F_ADD, 32'd100, 32'd4, 2'd1, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'd7) begin failures++; $display("FAIL fwd_exmem got=%h exp=7", ALU_Result); end
        drive_op(F_ADD, 32'd1, 32'd99, 2'd0, 2'd2, 1'b0, 32'd0, 32'd10);
        step();
        checks++; if (ALU_Result !== 32'd11 || dataInMemory !== 32'd10) begin
            failures++; $display("FAIL fwd_wb got=%h/%h exp=11/a", ALU_Result, dataInMemory); end
        drive_op(F_ADD, 32'd5, 32'd99, 2'd0, 2'd2, 1'b1, 32'hFFFFFFFF, 32'd10);
        step();
        checks++; if (ALU_Result !== 32'd4 || carryOutFlag !== 1'b1 || dataInMemory !== 32'd10) begin
            failures++; $display("FAIL fwd_imm got=%h/%b/%h exp=4/1/a", ALU_Result, carryOutFlag, dataInMemory); end
        drive_op(F_SUB, 32'd55, 32'd1, 2'd3, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'hFFFFFFFF || {carryOutFlag, overflowFlag, negativeFlag} !== 3'b001) begin
            failures++; $display("FAIL fwd_zero got=%h/%b exp=ffffffff/001", ALU_Result, {carryOutFlag, overflowFlag, negativeFlag}); end
        inValid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic seen;
        drive_op(F_ADD, 32'd20, 32'd22, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        checks++; if (ALU_Result !== 32'd42) begin failures++; $display("FAIL flush_pre got=%h exp=2a", ALU_Result); end
        drive_op(F_DIVU, 32'd100, 32'd7, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        inValid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++; if ({outValid, inReady, dbg_state} !== 3'b010 || ALU_Result !== 32'd42) begin
            failures++; $display("FAIL flush_busy got=%b/%h exp=010/2a", {outValid, inReady, dbg_state}, ALU_Result); end
        seen = 1'b0;
        repeat (30) begin
            step();
            if (outValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result got=1 exp=0"); end
        flush = 1'b1;
        drive_op(F_ADD, 32'd1, 32'd1, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        #1;
        checks++; if ({inReady, stall} !== 2'b01) begin failures++; $display("FAIL flush_idle_ready got=%b exp=01", {inReady, stall}); end
        step();
        flush = 1'b0; inValid = 1'b0;
        checks++; if (outValid !== 1'b0 || ALU_Result !== 32'd42) begin
            failures++; $display("FAIL flush_idle_block got=%b/%h exp=0/2a", outValid, ALU_Result); end
        drive_op(F_ADD, 32'd1, 32'd2, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        inValid = 1'b0; flush = 1'b1;
        #1;
        checks++; if (outValid !== 1'b1 || ALU_Result !== 32'd3) begin
            failures++; $display("FAIL flush_keep_valid got=%b/%h exp=1/3", outValid, ALU_Result); end
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        drive_op(F_MUL, 32'hFFFFFFFF, 32'd2, 2'd0, 2'd0, 1'b0, 32'd0, 32'd0);
        step();
        inValid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({outValid, inReady, dbg_state} !== 3'b010 || ALU_Result !== 32'd0 || dataInMemory !== 32'd0) begin
            failures++; $display("FAIL rstmid_state got=%b/%h/%h exp=010/0/0", {outValid, inReady, dbg_state}, ALU_Result, dataInMemory); end
        seen = 1'b0;
        repeat (40) begin
            step();
            if (outValid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_result got=1 exp=0"); end
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; flush = 1'b0; SIG_ALUSrc = 1'b0;
        immediate = '0; registerAData = '0; registerBData = '0; forwardWriteBackData = '0;
        SIG_Function = '0; SIG_ForwardA = '0; SIG_ForwardB = '0;
        test_reset();
        test_add_sub();
        test_logic();
        test_multicycle();
        test_forward();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_unit_mc.md
# execute_unit_mc

Parametrised, multi-cycle execute stage for the pipelined processor, sitting between the ID/EX and EX/MEM pipeline registers. It selects forwarded operands, chooses register or immediate for operand B, and runs single-cycle ALU operations or iterative multiply/divide operations. Results go into an internal EX/MEM result register with a valid strobe. A stall handshake holds the upstream pipeline while a multi-cycle operation is in flight.

## Interface
- WIDTH, 32, datapath width in bits (≥8).
- FUNC_W, 5, width of SIG_Function.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inValid  input  1  an operation is presented this cycle.
- inReady  output  1  the unit accepts the operation this cycle; acceptance = inValid & inReady.
- flush  input  1  abandons any in-flight or presented operation.
- immediate  input  WIDTH  sign-extended immediate.
- registerAData, registerBData  input  WIDTH  register file read data.
- forwardWriteBackData  input  WIDTH  forwarded writeback-stage data.
- SIG_Function  input  FUNC_W  operation code.
- SIG_ALUSrc  input  1  1 selects immediate as operand B.
- SIG_ForwardA, SIG_ForwardB  input  2  forwarding selects: 0 = register, 1 = ALU_Result (EX/MEM register), 2 = forwardWriteBackData, 3 = zero.
- outValid  output  1  ALU_Result, flags and dataInMemory hold a new result.
- ALU_Result  output  WIDTH  registered result.
- dataInMemory  output  WIDTH  registered forwarded operand B, taken before the ALUSrc mux.
- zeroFlag, carryOutFlag, overflowFlag, negativeFlag  output  1  registered flags.
- stall  output  1  equal to ~inReady.

## Operation
- **Operand sampling:** operands pass through the forwarding muxes and ALUSrc mux. They are captured only on the acceptance edge. Forwarding sources are not re-sampled during a multi-cycle operation.
- **Single-cycle codes:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, with shift amount B[log2(WIDTH)-1:0].
  - 8 SLT (signed), 9 SLTU; both give result 1 or 0.
- **Multi-cycle codes:**
  - 16 MUL: low WIDTH bits of the product.
  - 17 MULHU: high WIDTH bits of the unsigned product.
  - 18 DIVU: unsigned quotient.
  - 19 REMU: unsigned remainder.
- **Undefined codes:** single-cycle; result 0 and all flags 0.
- **Flags:**
  - zeroFlag = (result == 0).
  - negativeFlag = result[WIDTH-1].
  - carryOutFlag = carry out of A+B for ADD; borrow-free (A ≥ B unsigned) for SUB; 0 otherwise.
  - overflowFlag = two's-complement overflow for ADD/SUB; 0 otherwise.
- **Multiply:** shift-add, one partial product per cycle, WIDTH iterations, 2·WIDTH accumulator.
- **Divide:** restoring, one quotient bit per cycle, WIDTH iterations.
  - Divide by zero: DIVU returns all ones; REMU returns the dividend; zeroFlag follows the result.
- **FSM states:**
  - IDLE → (accept single-cycle) IDLE, result register loads.
  - IDLE → (accept multi-cycle) BUSY, counter = WIDTH-1.
  - BUSY → (counter == 0) IDLE, result register loads.
  - BUSY → (flush) IDLE, no result load.
- **Output register:** ALU_Result, flags and dataInMemory change only on a result load. They hold their value otherwise, so EX/MEM forwarding (select 1) sees a stable last result.

## Timing
- **Reset:** state IDLE, counter 0, inReady 1, stall 0, outValid 0, ALU_Result 0, dataInMemory 0, all flags 0. Reset overrides flush and inValid.
- **Single-cycle latency:** accept on edge k; outValid high for exactly one cycle after edge k.
- **Multi-cycle latency:** accept on edge k; inReady low from edge k to edge k+WIDTH; result loads on edge k+WIDTH; outValid high for one cycle after that edge.
- **Back-to-back:** inReady is high in the cycle outValid is asserted, so a new operation can be accepted in that same cycle. Single-cycle operations sustain one per clock.
- **flush:**
  - In IDLE, flush blocks acceptance that cycle.
  - In BUSY, flush returns to IDLE at the next edge with no outValid.
  - An outValid already asserted in the flush cycle is not retracted.
- **Ignored input:** inValid while inReady is low is ignored, with no queuing. Upstream must hold the operation using stall.
- **Reset mid-operation:** BUSY aborts on the reset edge and no result is produced.

## Test plan
- **Reset:** assert reset for 2 cycles with inValid = 1 → all outputs 0, inReady = 1, no outValid.
- **ADD:** A = 0x7FFFFFFF, B = 1 → next cycle ALU_Result 0x80000000, overflow 1, negative 1, carry 0. Follow with SUB 5−5 the next cycle → result 0, zero 1, carry 1, outValid on consecutive cycles.
- **MUL/MULHU:** 0xFFFFFFFF × 2 → MUL gives 0xFFFFFFFE and MULHU gives 0x00000001, each exactly 32 cycles after acceptance. stall is high for 32 cycles; inValid during stall is ignored.
- **Divide:** DIVU 100/7 → 14; REMU 100/7 → 2. DIVU x/0 with x = 0x1234 → 0xFFFFFFFF; REMU → 0x1234.
- **Forwarding:** ADD result 3, then ADD with SIG_ForwardA = 1, registerBData = 4 → 7. SIG_ForwardB = 2 with writeback data 10 and SIG_ALUSrc = 0 → dataInMemory 10. SIG_ALUSrc = 1 with immediate 0xFFFFFFFF → ALU operand B = −1.
- **Abort:** flush at cycle 10 of a DIVU → no outValid, inReady high the next cycle, ALU_Result unchanged. Reset mid-MUL behaves the same way, except that the outputs clear to 0.
